// File: rtl/video_pattern_pkg.sv
// ----------------------------------------------------------------------------
// video_pattern_pkg
// Shared constants for the video pattern engine: pattern mode codes and the
// colour palette. Colours are kept as 3-bit {R,G,B} on/off masks so the top
// level can expand them to any channel width (each set bit becomes a
// full-scale channel).
// ----------------------------------------------------------------------------
package video_pattern_pkg;

   // Pattern modes (codes 5..7 render black)
   localparam logic [2:0] MODE_SOLID = 3'd0;
   localparam logic [2:0] MODE_BARS  = 3'd1;
   localparam logic [2:0] MODE_CHECK = 3'd2;
   localparam logic [2:0] MODE_GRAD  = 3'd3;
   localparam logic [2:0] MODE_BOX   = 3'd4;

   // Palette as {R,G,B} channel-enable masks
   localparam logic [2:0] RGB_WHITE   = 3'b111;
   localparam logic [2:0] RGB_YELLOW  = 3'b110;
   localparam logic [2:0] RGB_CYAN    = 3'b011;
   localparam logic [2:0] RGB_GREEN   = 3'b010;
   localparam logic [2:0] RGB_MAGENTA = 3'b101;
   localparam logic [2:0] RGB_RED     = 3'b100;
   localparam logic [2:0] RGB_BLUE    = 3'b001;
   localparam logic [2:0] RGB_BLACK   = 3'b000;

   // Colour-bar order, left to right
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] m;
      case (idx)
         3'd0:    m = RGB_WHITE;
         3'd1:    m = RGB_YELLOW;
         3'd2:    m = RGB_CYAN;
         3'd3:    m = RGB_GREEN;
         3'd4:    m = RGB_MAGENTA;
         3'd5:    m = RGB_RED;
         3'd6:    m = RGB_BLUE;
         default: m = RGB_BLACK;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/pattern_box_tracker.sv
// ----------------------------------------------------------------------------
// pattern_box_tracker
// Position and bounce state of the moving box. Each axis steps by one pixel
// per frame start and reverses at its bound, taking the reversed step in the
// same update.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   fs         : frame-start strobe; one step per pulse
//   box_x/y    : top-left corner of the box. While fs is high these already
//                show the stepped position, so the frame-start pixel is
//                drawn with the new box.
// ----------------------------------------------------------------------------
module pattern_box_tracker
   import video_pattern_pkg::*;
#(
   parameter int COL_ADDR_WIDTH = 11,
   parameter int ROW_ADDR_WIDTH = 10,
   parameter int MAX_COL        = 1280,
   parameter int MAX_ROW        = 1024,
   parameter int BOX_SIZE       = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fs,
   output logic [COL_ADDR_WIDTH-1:0] box_x,
   output logic [ROW_ADDR_WIDTH-1:0] box_y
);

   localparam logic [COL_ADDR_WIDTH-1:0] X_LIM = COL_ADDR_WIDTH'(MAX_COL - BOX_SIZE);
   localparam logic [ROW_ADDR_WIDTH-1:0] Y_LIM = ROW_ADDR_WIDTH'(MAX_ROW - BOX_SIZE);

   logic [COL_ADDR_WIDTH-1:0] r_x, w_x_nxt;
   logic [ROW_ADDR_WIDTH-1:0] r_y, w_y_nxt;
   logic                      r_dx, r_dy;     // 1 = right / down
   logic                      w_dx_nxt, w_dy_nxt;

   always_comb begin
      // direction flips when sitting on the bound it is heading toward
      w_dx_nxt = r_dx;
      if (r_dx && (r_x == X_LIM))     w_dx_nxt = 1'b0;
      else if (!r_dx && (r_x == '0))  w_dx_nxt = 1'b1;
      w_dy_nxt = r_dy;
      if (r_dy && (r_y == Y_LIM))     w_dy_nxt = 1'b0;
      else if (!r_dy && (r_y == '0))  w_dy_nxt = 1'b1;
      w_x_nxt = w_dx_nxt ? r_x + 1'b1 : r_x - 1'b1;
      w_y_nxt = w_dy_nxt ? r_y + 1'b1 : r_y - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x  <= '0;
         r_y  <= '0;
         r_dx <= 1'b1;
         r_dy <= 1'b1;
      end else if (fs) begin
         r_x  <= w_x_nxt;
         r_y  <= w_y_nxt;
         r_dx <= w_dx_nxt;
         r_dy <= w_dy_nxt;
      end
   end

   assign box_x = fs ? w_x_nxt : r_x;
   assign box_y = fs ? w_y_nxt : r_y;

endmodule

// File: rtl/video_pattern_engine.sv
// ----------------------------------------------------------------------------
// video_pattern_engine
// Multi-mode test-pattern source. Each next_pixel request for (row, col)
// returns a registered RGB pixel one cycle later. Mode changes are latched
// only at frame start (request for pixel 0,0) so frames are never torn.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   next_pixel     : pixel request strobe
//   row_address    : requested row
//   col_address    : requested column
//   mode_sel       : requested pattern mode, sampled at frame start
//   data_out       : {R,G,B} pixel, held between requests
//   mode_active    : mode currently rendered
//   frame_count    : frame starts since reset, wraps at 2^16
// ----------------------------------------------------------------------------
module video_pattern_engine
   import video_pattern_pkg::*;
#(
   parameter int                    CH_WIDTH       = 8,
   parameter int                    DATA_WIDTH     = 3*CH_WIDTH,
   parameter int                    ROW_ADDR_WIDTH = 10,
   parameter int                    COL_ADDR_WIDTH = 11,
   parameter int                    MAX_ROW        = 1024,
   parameter int                    MAX_COL        = 1280,
   parameter int                    CHECK_LOG2     = 5,
   parameter int                    BOX_SIZE       = 64,
   parameter logic [DATA_WIDTH-1:0] SOLID_COLOR    = 24'h808080
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      next_pixel,
   input  logic [ROW_ADDR_WIDTH-1:0] row_address,
   input  logic [COL_ADDR_WIDTH-1:0] col_address,
   input  logic [2:0]                mode_sel,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic [2:0]                mode_active,
   output logic [15:0]               frame_count
);

   localparam int BAR_W = MAX_COL / 8;

   logic [DATA_WIDTH-1:0]     r_data;
   logic [2:0]                r_mode;
   logic [15:0]               r_frame;

   logic                      w_in_range, w_fs, w_in_box;
   logic [2:0]                w_mode, w_bar_idx;
   logic [DATA_WIDTH-1:0]     w_pix;
   logic [COL_ADDR_WIDTH-1:0] w_box_x;
   logic [ROW_ADDR_WIDTH-1:0] w_box_y;

   // Expand an {R,G,B} mask to full-scale channels
   function automatic logic [DATA_WIDTH-1:0] rgb_px(input logic [2:0] m);
      return {{CH_WIDTH{m[2]}}, {CH_WIDTH{m[1]}}, {CH_WIDTH{m[0]}}};
   endfunction

   assign w_in_range = (32'(row_address) < 32'(MAX_ROW)) &&
                       (32'(col_address) < 32'(MAX_COL));
   assign w_fs       = next_pixel && w_in_range &&
                       (row_address == '0) && (col_address == '0);
   // the frame-start pixel already uses the newly requested mode
   assign w_mode     = w_fs ? mode_sel : r_mode;

   pattern_box_tracker #(
      .COL_ADDR_WIDTH (COL_ADDR_WIDTH),
      .ROW_ADDR_WIDTH (ROW_ADDR_WIDTH),
      .MAX_COL        (MAX_COL),
      .MAX_ROW        (MAX_ROW),
      .BOX_SIZE       (BOX_SIZE)
   ) u_box (
      .clk   (clk),
      .rst_n (rst_n),
      .fs    (w_fs),
      .box_x (w_box_x),
      .box_y (w_box_y)
   );

   // Bar index from a ladder of constant thresholds instead of a divider
   always_comb begin
      w_bar_idx = '0;
      for (int i = 1; i < 8; i++)
         if (32'(col_address) >= 32'(i*BAR_W)) w_bar_idx = 3'(i);
   end

   assign w_in_box = (col_address >= w_box_x) &&
                     (32'(col_address) < 32'(w_box_x) + 32'(BOX_SIZE)) &&
                     (row_address >= w_box_y) &&
                     (32'(row_address) < 32'(w_box_y) + 32'(BOX_SIZE));

   always_comb begin
      w_pix = '0;
      case (w_mode)
         MODE_SOLID: w_pix = SOLID_COLOR;
         MODE_BARS:  w_pix = rgb_px(bar_rgb(w_bar_idx));
         MODE_CHECK: w_pix = rgb_px((col_address[CHECK_LOG2] ^ row_address[CHECK_LOG2])
                                    ? RGB_WHITE : RGB_BLACK);
         MODE_GRAD:  w_pix = {3{col_address[CH_WIDTH-1:0]}};
         MODE_BOX:   w_pix = rgb_px(w_in_box ? RGB_WHITE : RGB_BLUE);
         default:    w_pix = rgb_px(RGB_BLACK);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_mode  <= MODE_SOLID;
         r_frame <= '0;
      end else begin
         if (next_pixel) r_data <= w_in_range ? w_pix : '0;
         if (w_fs) begin
            r_mode  <= mode_sel;
            r_frame <= r_frame + 16'd1;
         end
      end
   end

   assign data_out    = r_data;
   assign mode_active = r_mode;
   assign frame_count = r_frame;

endmodule

// File: tb/tb_video_pattern_engine.sv
// ----------------------------------------------------------------------------
// tb_video_pattern_engine
// Directed checks of video_pattern_engine with hand-computed pixel values.
// The row address is widened to 11 bits so out-of-range rows can be driven.
// ----------------------------------------------------------------------------
module tb_video_pattern_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        next_pixel;
   logic [10:0] row_address;
   logic [10:0] col_address;
   logic [2:0]  mode_sel;
   logic [23:0] data_out;
   logic [2:0]  mode_active;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;
   int nfs    = 0;

   video_pattern_engine #(
      .ROW_ADDR_WIDTH (11)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .next_pixel  (next_pixel),
      .row_address (row_address),
      .col_address (col_address),
      .mode_sel    (mode_sel),
      .data_out    (data_out),
      .mode_active (mode_active),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // single request; returns #1 after the capturing edge
   task automatic px(input int r, input int c);
      @(negedge clk);
      row_address = 11'(r);
      col_address = 11'(c);
      next_pixel  = 1'b1;
      @(posedge clk);
      #1 next_pixel = 1'b0;
   endtask

   task automatic fs(input logic [2:0] m);
      mode_sel = m;
      px(0, 0);
      nfs++;
   endtask

   initial begin
      rst_n = 1'b0; next_pixel = 1'b0; row_address = '0; col_address = '0;
      mode_sel = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data",  32'(data_out),    32'h0);
      chk("rst_mode",  32'(mode_active), 32'h0);
      chk("rst_frame", 32'(frame_count), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // colour bars
      fs(3'd1);
      chk("bars_c0",    32'(data_out),    32'hFFFFFF);
      chk("bars_mode",  32'(mode_active), 32'd1);
      chk("bars_frame", 32'(frame_count), 32'd1);
      px(0, 160);  chk("bars_c160",  32'(data_out), 32'hFFFF00);
      repeat (3) @(posedge clk);
      #1 chk("bars_hold", 32'(data_out), 32'hFFFF00);
      px(0, 1279); chk("bars_c1279", 32'(data_out), 32'h000000);
      px(0, 1280); chk("col_oor",    32'(data_out), 32'h000000);

      // mid-frame mode change ignored
      mode_sel = 3'd3;
      px(500, 300); chk("midframe_bars", 32'(data_out),    32'hFFFF00);
      chk("midframe_mode", 32'(mode_active), 32'd1);

      // gradient from next frame
      fs(3'd3);
      chk("grad_c0",   32'(data_out),    32'h000000);
      px(0, 300); chk("grad_c300", 32'(data_out), 32'h2C2C2C);
      chk("grad_mode", 32'(mode_active), 32'd3);

      // checkerboard
      fs(3'd2);
      px(0, 32);  chk("chk_0_32",  32'(data_out), 32'hFFFFFF);
      px(32, 32); chk("chk_32_32", 32'(data_out), 32'h000000);
      px(31, 31); chk("chk_31_31", 32'(data_out), 32'h000000);

      // solid and reserved mode
      fs(3'd0); chk("solid",  32'(data_out), 32'h808080);
      fs(3'd5); chk("mode5",  32'(data_out), 32'h000000);
      px(10, 10); chk("mode5_px", 32'(data_out), 32'h000000);

      // gapped out-of-range rows in bars mode
      fs(3'd1);
      px(0, 160); chk("gap_pre", 32'(data_out), 32'hFFFF00);
      for (int k = 0; k < 4; k++) begin
         px(1100, 0); chk("row_oor", 32'(data_out), 32'h000000);
         repeat (3) @(posedge clk);
         #1 chk("row_oor_hold", 32'(data_out), 32'h000000);
      end
      chk("oor_frame", 32'(frame_count), 32'd6);

      // back-to-back requests
      @(negedge clk);
      row_address = 11'd1; col_address = 11'd0; next_pixel = 1'b1;
      @(negedge clk);
      chk("b2b_0", 32'(data_out), 32'hFFFFFF);
      col_address = 11'd320;
      @(negedge clk);
      next_pixel = 1'b0;
      chk("b2b_1", 32'(data_out), 32'h00FFFF);

      // moving box: box position == frame number until 960 on both axes
      while (nfs < 960) fs(3'd4);
      chk("box960_frame", 32'(frame_count), 32'd960);
      px(960, 960);   chk("box960_in",   32'(data_out), 32'hFFFFFF);
      px(959, 960);   chk("box960_above",32'(data_out), 32'h0000FF);
      px(1023, 1023); chk("box960_far",  32'(data_out), 32'hFFFFFF);
      px(1023, 1024); chk("box960_right",32'(data_out), 32'h0000FF);
      while (nfs < 1216) fs(3'd4);
      // bx=1216, by=960-256=704
      px(704, 1216); chk("box1216_in",   32'(data_out), 32'hFFFFFF);
      px(704, 1215); chk("box1216_left", 32'(data_out), 32'h0000FF);
      px(767, 1279); chk("box1216_far",  32'(data_out), 32'hFFFFFF);
      fs(3'd4);
      // bx=1215 after bounce, by=703
      chk("box1217_frame", 32'(frame_count), 32'd1217);
      px(703, 1215); chk("box1217_in",   32'(data_out), 32'hFFFFFF);
      px(703, 1214); chk("box1217_left", 32'(data_out), 32'h0000FF);
      px(703, 1279); chk("box1217_right",32'(data_out), 32'h0000FF);
      px(766, 1278); chk("box1217_far",  32'(data_out), 32'hFFFFFF);
      px(767, 1278); chk("box1217_below",32'(data_out), 32'h0000FF);

      // async reset mid-frame
      px(5, 5); chk("pre_rst", 32'(data_out), 32'h0000FF);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data",  32'(data_out),    32'h0);
      chk("arst_mode",  32'(mode_active), 32'h0);
      chk("arst_frame", 32'(frame_count), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_hold", 32'(data_out), 32'h0);
      fs(3'd4);
      chk("post_rst_frame", 32'(frame_count), 32'd1);
      chk("post_rst_c0",    32'(data_out),    32'h0000FF);
      px(1, 1);  chk("post_rst_in",   32'(data_out), 32'hFFFFFF);
      px(1, 0);  chk("post_rst_left", 32'(data_out), 32'h0000FF);
      px(64, 64);chk("post_rst_far",  32'(data_out), 32'hFFFFFF);
      px(1, 65); chk("post_rst_right",32'(data_out), 32'h0000FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
